// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: signal bundle between the board button/switch logic and the
// processor step controller.
//
// Signals:
//   step_pulse  one-cycle step request from the debouncer
//   run_mode    level switch: 1 = free run, 0 = single-step
//   halt_req    level from the core (breakpoint/ecall), stops free run
//   cpu_en      clock-enable to the processor
//   busy        controller is not idle
//   step_led    stretched indication of an accepted step
//   step_count  number of completed single steps (wraps)
//
// Modports:
//   master  drives the requests, observes the controller outputs
//   slave   the controller itself
interface cpu_step_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             step_pulse;
    logic             run_mode;
    logic             halt_req;
    logic             cpu_en;
    logic             busy;
    logic             step_led;
    logic [CNT_W-1:0] step_count;

    modport master (
        output step_pulse,
        output run_mode,
        output halt_req,
        input  cpu_en,
        input  busy,
        input  step_led,
        input  step_count
    );

    modport slave (
        input  step_pulse,
        input  run_mode,
        input  halt_req,
        output cpu_en,
        output busy,
        output step_led,
        output step_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns debounced step pulses and the run/halt levels into a
// clock-enable for the RV32I core, plus a stretched step LED and a counter of
// completed single steps.
//
// Ports:
//   Clock   system clock, all logic on the rising edge
//   Reset   synchronous, active-high
//   bus     cpu_step_ctrl_if.slave (step_pulse, run_mode, halt_req in;
//           cpu_en, busy, step_led, step_count out)
//
// Parameters:
//   STEP_CYCLES  cpu_en cycles per accepted step pulse (>=1)
//   RUN_DIV      in run mode cpu_en is high one cycle in RUN_DIV (>=1)
//   LED_TICKS    cycles step_led stays high after an accepted step (>=1)
//   CNT_W        width of step_count
module cpu_step_ctrl #(
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned RUN_DIV     = 1,
    parameter int unsigned LED_TICKS   = 12500000,
    parameter int unsigned CNT_W       = 16
) (
    input logic            Clock,
    input logic            Reset,
    cpu_step_ctrl_if.slave bus
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int unsigned LED_W  = $clog2(LED_TICKS + 1);

    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
    localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_TICKS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STEP   = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
    logic [LED_W-1:0]  led_cnt_q,  led_cnt_d;
    logic [CNT_W-1:0]  count_q,    count_d;

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        // div_cnt only runs inside RUN, so every RUN entry starts at phase 0
        div_cnt_d  = '0;
        count_d    = count_q;
        led_cnt_d  = (led_cnt_q != '0) ? led_cnt_q - LED_W'(1) : '0;

        case (state_q)
            IDLE: begin
                // run_mode wins over a simultaneous step pulse; the pulse is dropped
                if (bus.run_mode && !bus.halt_req) begin
                    state_d = RUN;
                end else if (bus.step_pulse) begin
                    state_d    = STEP;
                    step_cnt_d = STEP_LOAD;
                    led_cnt_d  = LED_LOAD;
                end
            end
            STEP: begin
                // all inputs ignored: a step always runs to completion
                if (step_cnt_q == '0) begin
                    state_d = IDLE;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                end
            end
            RUN: begin
                div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
                if (bus.halt_req) begin
                    state_d = HALTED;
                end else if (!bus.run_mode) begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                if (!bus.run_mode) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            div_cnt_q  <= '0;
            led_cnt_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            div_cnt_q  <= div_cnt_d;
            led_cnt_q  <= led_cnt_d;
            count_q    <= count_d;
        end
    end

    assign bus.cpu_en     = (state_q == STEP) || ((state_q == RUN) && (div_cnt_q == '0));
    assign bus.busy       = (state_q != IDLE);
    assign bus.step_led   = (led_cnt_q != '0);
    assign bus.step_count = count_q;

endmodule
